mem_access_unit: RTL and testbench

Load/store unit for the MEM stage of the 5-stage RISC-V pipeline, placed between the EX_MEM register and the MEM_WB register. It turns the EX_MEM load/store controls into a request/acknowledge transaction on the data-memory bus, with variable latency. Store data is lane-aligned with byte strobes, and load data is sign- or zero-extended before it reaches `read_data_in` of MEM_WB. While a transaction is outstanding it stalls the upstream pipeline and bubbles writeback.

---
 rtl/mem_access_unit.sv | 175 +++++++++++++++++
 tb/tb_mem_access_unit.sv | 263 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/mem_access_unit.sv
// mem_access_unit: MEM-stage load/store unit. Turns EX_MEM load/store
// controls into a req/ack transaction on the data-memory bus, aligns store
// data into byte lanes, extends load data, and stalls the pipeline while a
// transaction is outstanding.
// Optional feature: define LSU_TIMEOUT_EN to abort a WAIT after
// TIMEOUT_CYCLES cycles without dmem_ack (bus_err pulse, empty load result).
module mem_access_unit #(
  parameter int unsigned TIMEOUT_CYCLES = 255
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [31:0] alu_out_in,
  input  logic [31:0] write_data_in,
  input  logic [2:0]  funct3_in,
  input  logic        MemRead_in,
  input  logic        MemWrite_in,
  output logic [31:0] read_data_out,
  output logic        stall,
  output logic        wb_kill,
  output logic        misalign,
  output logic        bus_err,
  output logic        dmem_req,
  output logic        dmem_we,
  output logic [31:0] dmem_addr,
  output logic [31:0] dmem_wdata,
  output logic [3:0]  dmem_wstrb,
  input  logic        dmem_ack,
  input  logic [31:0] dmem_rdata
);

  typedef enum logic [1:0] {S_IDLE, S_WAIT, S_DONE} state_t;

  state_t      r_state;
  logic [31:0] r_rdata;
  logic [2:0]  r_f3;
  logic [1:0]  r_off;

  logic        w_acc;
  logic        w_is_b;
  logic        w_is_h;
  logic        w_aligned;
  logic [31:0] w_wdata;
  logic [3:0]  w_wstrb;
  logic [7:0]  w_lbyte;
  logic [15:0] w_lhalf;
  logic [31:0] w_load;

`ifdef LSU_TIMEOUT_EN
  localparam int unsigned CW =
    ($clog2(TIMEOUT_CYCLES + 1) > 8) ? $clog2(TIMEOUT_CYCLES + 1) : 8;
  localparam logic [CW-1:0] TO_LAST = CW'(TIMEOUT_CYCLES - 1);
  logic [CW-1:0] r_cnt;
  logic          r_bus_err;
`endif

  // funct3[1:0] alone selects the size: 00 byte, 01 half, anything else word.
  assign w_acc  = MemRead_in | MemWrite_in;
  assign w_is_b = (funct3_in[1:0] == 2'b00);
  assign w_is_h = (funct3_in[1:0] == 2'b01);

  // Alignment check for the current EX_MEM access
  always_comb begin
    w_aligned = 1'b1;
    if (w_is_h)
      w_aligned = ~alu_out_in[0];
    else if (!w_is_b)
      w_aligned = (alu_out_in[1:0] == 2'b00);
  end

  // Store lane replication and byte strobes (zero strobes for loads)
  always_comb begin
    if (w_is_b) begin
      w_wdata = {4{write_data_in[7:0]}};
      w_wstrb = 4'b0001 << alu_out_in[1:0];
    end else if (w_is_h) begin
      w_wdata = {2{write_data_in[15:0]}};
      w_wstrb = alu_out_in[1] ? 4'b1100 : 4'b0011;
    end else begin
      w_wdata = write_data_in;
      w_wstrb = 4'b1111;
    end
    if (!MemWrite_in)
      w_wstrb = '0;
  end

  // Load lane select and extension from the word returned on ack
  always_comb begin
    case (r_off)
      2'd0:    w_lbyte = dmem_rdata[7:0];
      2'd1:    w_lbyte = dmem_rdata[15:8];
      2'd2:    w_lbyte = dmem_rdata[23:16];
      default: w_lbyte = dmem_rdata[31:24];
    endcase
    w_lhalf = r_off[1] ? dmem_rdata[31:16] : dmem_rdata[15:0];
    case (r_f3)
      3'b000:  w_load = {{24{w_lbyte[7]}}, w_lbyte};
      3'b001:  w_load = {{16{w_lhalf[15]}}, w_lhalf};
      3'b100:  w_load = {24'd0, w_lbyte};
      3'b101:  w_load = {16'd0, w_lhalf};
      default: w_load = dmem_rdata;
    endcase
  end

  // Transaction FSM with registered bus outputs and load result
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state    <= S_IDLE;
      r_rdata    <= '0;
      r_f3       <= '0;
      r_off      <= '0;
      dmem_req   <= 1'b0;
      dmem_we    <= 1'b0;
      dmem_addr  <= '0;
      dmem_wdata <= '0;
      dmem_wstrb <= '0;
`ifdef LSU_TIMEOUT_EN
      r_cnt      <= '0;
      r_bus_err  <= 1'b0;
`endif
    end else begin
`ifdef LSU_TIMEOUT_EN
      r_bus_err <= 1'b0;
`endif
      case (r_state)
        S_IDLE: begin
          if (w_acc && w_aligned) begin
            dmem_req   <= 1'b1;
            dmem_we    <= MemWrite_in;
            dmem_addr  <= {alu_out_in[31:2], 2'b00};
            dmem_wdata <= w_wdata;
            dmem_wstrb <= w_wstrb;
            r_f3       <= funct3_in;
            r_off      <= alu_out_in[1:0];
`ifdef LSU_TIMEOUT_EN
            r_cnt      <= '0;
`endif
            r_state    <= S_WAIT;
          end
        end
        S_WAIT: begin
          if (dmem_ack) begin
            r_rdata  <= dmem_we ? '0 : w_load;
            dmem_req <= 1'b0;
            r_state  <= S_DONE;
          end
`ifdef LSU_TIMEOUT_EN
          else if (r_cnt == TO_LAST) begin
            r_bus_err <= 1'b1;
            r_rdata   <= '0;
            dmem_req  <= 1'b0;
            r_state   <= S_DONE;
          end else begin
            r_cnt <= r_cnt + 1'b1;
          end
`endif
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end

  // Pipeline-facing controls; gated by rst so nothing leaks out during reset
  assign stall         = ~rst & w_acc & w_aligned & (r_state != S_DONE);
  assign misalign      = ~rst & w_acc & ~w_aligned & (r_state == S_IDLE);
  assign wb_kill       = stall | misalign;
  assign read_data_out = (r_state == S_DONE) ? r_rdata : '0;

`ifdef LSU_TIMEOUT_EN
  assign bus_err = r_bus_err;
`else
  // TIMEOUT_CYCLES has no effect without the timeout counter
  assign bus_err = 1'b0 & (TIMEOUT_CYCLES != 0);
`endif

endmodule

// File: tb/tb_mem_access_unit.sv
// tb_mem_access_unit: directed bench for mem_access_unit. Load results are
// queued as expected values when an access is driven and compared when the
// unit reaches DONE.
module tb_mem_access_unit;

  logic        clk = 1'b0;
  logic        rst;
  logic [31:0] alu_out_in;
  logic [31:0] write_data_in;
  logic [2:0]  funct3_in;
  logic        MemRead_in;
  logic        MemWrite_in;
  logic [31:0] read_data_out;
  logic        stall;
  logic        wb_kill;
  logic        misalign;
  logic        bus_err;
  logic        dmem_req;
  logic        dmem_we;
  logic [31:0] dmem_addr;
  logic [31:0] dmem_wdata;
  logic [3:0]  dmem_wstrb;
  logic        dmem_ack;
  logic [31:0] dmem_rdata;

  int unsigned checks = 0;
  int unsigned errors = 0;
  logic [31:0] sb_q[$];

  always #5 clk = ~clk;

  mem_access_unit #(.TIMEOUT_CYCLES(4)) dut (
    .clk           (clk),
    .rst           (rst),
    .alu_out_in    (alu_out_in),
    .write_data_in (write_data_in),
    .funct3_in     (funct3_in),
    .MemRead_in    (MemRead_in),
    .MemWrite_in   (MemWrite_in),
    .read_data_out (read_data_out),
    .stall         (stall),
    .wb_kill       (wb_kill),
    .misalign      (misalign),
    .bus_err       (bus_err),
    .dmem_req      (dmem_req),
    .dmem_we       (dmem_we),
    .dmem_addr     (dmem_addr),
    .dmem_wdata    (dmem_wdata),
    .dmem_wstrb    (dmem_wstrb),
    .dmem_ack      (dmem_ack),
    .dmem_rdata    (dmem_rdata)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic chk1(input string tag, input logic obs, input logic exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%b expected=%b", tag, obs, exp);
    end
  endtask

  task automatic chk_all_zero(input string tag);
    chk1({tag, ".stall"},    stall,    1'b0);
    chk1({tag, ".wb_kill"},  wb_kill,  1'b0);
    chk1({tag, ".misalign"}, misalign, 1'b0);
    chk1({tag, ".bus_err"},  bus_err,  1'b0);
    chk1({tag, ".req"},      dmem_req, 1'b0);
    chk1({tag, ".we"},       dmem_we,  1'b0);
    chk ({tag, ".addr"},     dmem_addr,     32'h0);
    chk ({tag, ".wdata"},    dmem_wdata,    32'h0);
    chk ({tag, ".wstrb"},    {28'd0, dmem_wstrb}, 32'h0);
    chk ({tag, ".rdata"},    read_data_out, 32'h0);
  endtask

  task automatic clear_inputs();
    MemRead_in    = 1'b0;
    MemWrite_in   = 1'b0;
    alu_out_in    = 32'h0;
    write_data_in = 32'h0;
    funct3_in     = 3'b000;
  endtask

  // One aligned access; ack arrives in the ack_wait-th WAIT cycle.
  task automatic access(input string tag, input logic rd, input logic wr,
                        input logic [2:0] f3, input logic [31:0] addr,
                        input logic [31:0] wd, input logic [31:0] word,
                        input int unsigned ack_wait,
                        input logic [31:0] exp_addr, input logic [31:0] exp_wdata,
                        input logic [3:0] exp_wstrb, input logic exp_we,
                        input logic [31:0] exp_rdata);
    int unsigned st_cnt;
    logic [31:0] exp_q;
    @(negedge clk);
    MemRead_in = rd; MemWrite_in = wr; funct3_in = f3;
    alu_out_in = addr; write_data_in = wd;
    if (rd && !wr) sb_q.push_back(exp_rdata);
    #1;
    chk1({tag, ".stall_T"}, stall, 1'b1);
    chk1({tag, ".req_T"},   dmem_req, 1'b0);
    st_cnt = 32'(stall);
    for (int unsigned k = 1; k <= ack_wait; k++) begin
      @(negedge clk);
      dmem_ack   = (k == ack_wait);
      dmem_rdata = (k == ack_wait) ? word : (32'hDEAD_0000 | k);
      #1;
      chk1({tag, ".req_wait"},   dmem_req, 1'b1);
      chk1({tag, ".we_wait"},    dmem_we,  exp_we);
      chk ({tag, ".addr_wait"},  dmem_addr,  exp_addr);
      chk ({tag, ".wdata_wait"}, dmem_wdata, exp_wdata);
      chk ({tag, ".wstrb_wait"}, {28'd0, dmem_wstrb}, {28'd0, exp_wstrb});
      st_cnt += 32'(stall);
    end
    @(negedge clk);
    dmem_ack = 1'b0; dmem_rdata = 32'h5A5A_5A5A;
    #1;
    chk1({tag, ".stall_done"},   stall,    1'b0);
    chk1({tag, ".wbkill_done"},  wb_kill,  1'b0);
    chk1({tag, ".req_done"},     dmem_req, 1'b0);
    st_cnt += 32'(stall);
    chk({tag, ".stall_cycles"}, st_cnt, ack_wait + 1);
    if (rd && !wr) begin
      if (sb_q.size() == 0) begin
        checks++; errors++;
        $error("FAIL %s.scoreboard observed=empty expected=entry", tag);
      end else begin
        exp_q = sb_q.pop_front();
        chk({tag, ".rdata"}, read_data_out, exp_q);
      end
    end
    @(negedge clk);
    clear_inputs();
    #1;
    chk1({tag, ".stall_after"}, stall, 1'b0);
    chk ({tag, ".rdata_after"}, read_data_out, 32'h0);
  endtask

  task automatic misaligned(input string tag, input logic rd, input logic wr,
                            input logic [2:0] f3, input logic [31:0] addr);
    @(negedge clk);
    MemRead_in = rd; MemWrite_in = wr; funct3_in = f3; alu_out_in = addr;
    #1;
    chk1({tag, ".misalign"}, misalign, 1'b1);
    chk1({tag, ".stall"},    stall,    1'b0);
    chk1({tag, ".wb_kill"},  wb_kill,  1'b1);
    chk1({tag, ".req"},      dmem_req, 1'b0);
    chk ({tag, ".rdata"},    read_data_out, 32'h0);
    @(negedge clk);
    clear_inputs();
    #1;
    chk1({tag, ".req_next"},      dmem_req, 1'b0);
    chk1({tag, ".misalign_next"}, misalign, 1'b0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog simulation did not finish");
    $fatal(1);
  end

  initial begin
    rst = 1'b1;
    clear_inputs();
    dmem_ack = 1'b0; dmem_rdata = 32'h0;
    MemRead_in = 1'b1; alu_out_in = 32'h100; funct3_in = 3'b010;
    #12;
    chk_all_zero("reset");
    clear_inputs();
    @(negedge clk); rst = 1'b0;
    #1;
    chk_all_zero("post_reset");

    // Non-memory instruction: no stall, no kill, no data
    @(negedge clk); #1;
    chk1("nomem.stall", stall, 1'b0);
    chk1("nomem.wb_kill", wb_kill, 1'b0);
    chk ("nomem.rdata", read_data_out, 32'h0);

    // Loads
    access("lb_103",  1'b1, 1'b0, 3'b000, 32'h103, 32'h0, 32'h80FF_0000, 1, 32'h100, 32'h0, 4'b0000, 1'b0, 32'hFFFF_FF80);
    access("lbu_103", 1'b1, 1'b0, 3'b100, 32'h103, 32'h0, 32'h80FF_0000, 1, 32'h100, 32'h0, 4'b0000, 1'b0, 32'h0000_0080);
    access("lhu_102", 1'b1, 1'b0, 3'b101, 32'h102, 32'h0, 32'h8001_1234, 1, 32'h100, 32'h0, 4'b0000, 1'b0, 32'h0000_8001);
    access("lh_102",  1'b1, 1'b0, 3'b001, 32'h102, 32'h0, 32'h8001_1234, 2, 32'h100, 32'h0, 4'b0000, 1'b0, 32'hFFFF_8001);
    access("lbu_101", 1'b1, 1'b0, 3'b100, 32'h101, 32'h0, 32'h8001_1234, 1, 32'h100, 32'h0, 4'b0000, 1'b0, 32'h0000_0012);
    access("lw_100",  1'b1, 1'b0, 3'b010, 32'h100, 32'h0, 32'h8001_1234, 1, 32'h100, 32'h0, 4'b0000, 1'b0, 32'h8001_1234);
    access("lw_f011", 1'b1, 1'b0, 3'b011, 32'h108, 32'h0, 32'hCAFE_F00D, 1, 32'h108, 32'h0, 4'b0000, 1'b0, 32'hCAFE_F00D);

    // Stores
    access("sb_101",  1'b0, 1'b1, 3'b000, 32'h101, 32'h1234_56AB, 32'h0, 1, 32'h100, 32'hABAB_ABAB, 4'b0010, 1'b1, 32'h0);
    access("sh_102",  1'b0, 1'b1, 3'b001, 32'h102, 32'h7777_BEEF, 32'h0, 1, 32'h100, 32'hBEEF_BEEF, 4'b1100, 1'b1, 32'h0);
    access("sh_100",  1'b0, 1'b1, 3'b001, 32'h100, 32'h0000_1357, 32'h0, 1, 32'h100, 32'h1357_1357, 4'b0011, 1'b1, 32'h0);
    access("sbu_103", 1'b0, 1'b1, 3'b100, 32'h103, 32'h0000_005C, 32'h0, 1, 32'h100, 32'h5C5C_5C5C, 4'b1000, 1'b1, 32'h0);
    access("sw_both", 1'b1, 1'b1, 3'b010, 32'h104, 32'hDEAD_BEEF, 32'h0, 1, 32'h104, 32'hDEAD_BEEF, 4'b1111, 1'b1, 32'h0);

    // Misaligned accesses
    misaligned("mis_lw_102", 1'b1, 1'b0, 3'b010, 32'h102);
    misaligned("mis_sh_101", 1'b0, 1'b1, 3'b001, 32'h101);

    // Long wait: bus stable for 5 cycles, stall held 6
    access("lw_delay5", 1'b1, 1'b0, 3'b010, 32'h10C, 32'h0, 32'h0BAD_C0DE, 5, 32'h10C, 32'h0, 4'b0000, 1'b0, 32'h0BAD_C0DE);

    // Reset in the 3rd WAIT cycle abandons the transaction
    @(negedge clk);
    MemRead_in = 1'b1; funct3_in = 3'b010; alu_out_in = 32'h110;
    #1;
    chk1("rstwait.stall_T", stall, 1'b1);
    for (int unsigned k = 1; k <= 2; k++) begin
      @(negedge clk); #1;
      chk1("rstwait.req", dmem_req, 1'b1);
    end
    @(negedge clk);
    rst = 1'b1;
    #1;
    chk_all_zero("rstwait.in_reset");
    clear_inputs();
    @(negedge clk); rst = 1'b0;
    @(negedge clk);
    dmem_ack = 1'b1; dmem_rdata = 32'h1111_1111;
    #1;
    chk1("rstwait.late_ack_req", dmem_req, 1'b0);
    chk1("rstwait.late_ack_stall", stall, 1'b0);
    @(negedge clk);
    dmem_ack = 1'b0;
    #1;
    chk_all_zero("rstwait.after_ack");
    access("lw_after_rst", 1'b1, 1'b0, 3'b010, 32'h114, 32'h0, 32'h2468_ACE0, 1, 32'h114, 32'h0, 4'b0000, 1'b0, 32'h2468_ACE0);

`ifdef LSU_TIMEOUT_EN
    // No ack: abort after 4 WAIT cycles
    @(negedge clk);
    MemRead_in = 1'b1; funct3_in = 3'b010; alu_out_in = 32'h200;
    #1;
    chk1("timeout.stall_T", stall, 1'b1);
    for (int unsigned k = 1; k <= 4; k++) begin
      @(negedge clk); #1;
      chk1("timeout.req_wait", dmem_req, 1'b1);
      chk1("timeout.buserr_wait", bus_err, 1'b0);
    end
    @(negedge clk); #1;
    chk1("timeout.bus_err", bus_err, 1'b1);
    chk1("timeout.req_done", dmem_req, 1'b0);
    chk1("timeout.stall_done", stall, 1'b0);
    chk ("timeout.rdata", read_data_out, 32'h0);
    @(negedge clk);
    clear_inputs();
    #1;
    chk1("timeout.bus_err_after", bus_err, 1'b0);
    chk1("timeout.req_after", dmem_req, 1'b0);
`endif

    chk("scoreboard.empty", sb_q.size(), 32'd0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
